// File: rtl/management_bus_pkg.sv
// -----------------------------------------------------------------------------
// management_bus_pkg
// Shared definitions for the Wishbone-to-core-management bridge:
//   - bridgeState_t : bridge FSM state encoding
//   - MANAGEMENT_ADDRESS_WIDTH : width of the management byte address
//   - ERROR_READ_VALUE / WRITE_RESPONSE_VALUE : data returned on error / write
// -----------------------------------------------------------------------------
package management_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    ACK     = 2'd2,
    ERROR   = 2'd3
  } bridgeState_t;

  localparam int unsigned MANAGEMENT_ADDRESS_WIDTH = 20;
  localparam logic [31:0] ERROR_READ_VALUE         = 32'hFFFF_FFFF;
  localparam logic [31:0] WRITE_RESPONSE_VALUE     = 32'h0000_0000;

endpackage

// File: rtl/wishbone_management_bridge_if.sv
// -----------------------------------------------------------------------------
// wishbone_management_bridge_if
// Wishbone classic bus bundle between the SoC interconnect (master) and the
// management bridge (slave).
//   wb_cyc_i/wb_stb_i/wb_we_i/wb_sel_i/wb_adr_i/wb_data_i : master -> slave
//   wb_ack_o/wb_error_o/wb_data_o                         : slave -> master
// -----------------------------------------------------------------------------
interface wishbone_management_bridge_if;
  import management_bus_pkg::*;

  logic                                wb_cyc_i;
  logic                                wb_stb_i;
  logic                                wb_we_i;
  logic [3:0]                          wb_sel_i;
  logic [MANAGEMENT_ADDRESS_WIDTH-1:0] wb_adr_i;
  logic [31:0]                         wb_data_i;
  logic                                wb_ack_o;
  logic                                wb_error_o;
  logic [31:0]                         wb_data_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    input  wb_ack_o, wb_error_o, wb_data_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    output wb_ack_o, wb_error_o, wb_data_o
  );

endinterface

// File: rtl/busy_timeout_counter.sv
// -----------------------------------------------------------------------------
// busy_timeout_counter
// Counts cycles a management request has been stalled by busy and flags when
// the tolerated number of busy cycles is used up.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the count (new request accepted)
//   increment : one more busy cycle observed
//   expired   : count has reached TIMEOUT_CYCLES-1
// The 8-bit count saturates at 8'hFF instead of wrapping.
// -----------------------------------------------------------------------------
module busy_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic increment,
  output logic expired
);

  localparam logic [7:0] EXPIRE_COUNT = 8'(TIMEOUT_CYCLES - 32'd1);

  logic [7:0] busyCount;

  // Busy-cycle count: cleared per request, saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busyCount <= 8'd0;
    end else if (clear) begin
      busyCount <= 8'd0;
    end else if (increment && (busyCount != 8'hFF)) begin
      busyCount <= busyCount + 8'd1;
    end else begin
      busyCount <= busyCount;
    end
  end

  assign expired = (busyCount == EXPIRE_COUNT);

endmodule

// File: rtl/wishbone_management_bridge.sv
// -----------------------------------------------------------------------------
// wishbone_management_bridge
// Wishbone classic slave that registers each bus cycle into a single request
// on the core management interface, holds it while management is busy, and
// terminates the cycle with wb_ack_o (data returned) or, after TIMEOUT_CYCLES
// busy cycles, with wb_error_o (data 32'hFFFF_FFFF).
//   clk, rst                   : clock, asynchronous active-high reset
//   wb                         : Wishbone slave bundle
//   wb_management_writeEnable  : write request (REQUEST state only)
//   wb_management_readEnable   : read request (REQUEST state only)
//   wb_management_byteSelect   : latched byte lanes
//   wb_management_address      : latched byte address
//   wb_management_writeData    : latched write data
//   wb_management_readData     : read data from management
//   wb_management_busy         : management stalled (serving JTAG)
// All outputs are registered.
// -----------------------------------------------------------------------------
module wishbone_management_bridge
  import management_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  wishbone_management_bridge_if.slave         wb,
  output logic                                wb_management_writeEnable,
  output logic                                wb_management_readEnable,
  output logic [3:0]                          wb_management_byteSelect,
  output logic [MANAGEMENT_ADDRESS_WIDTH-1:0] wb_management_address,
  output logic [31:0]                         wb_management_writeData,
  input  logic [31:0]                         wb_management_readData,
  input  logic                                wb_management_busy
);

  bridgeState_t state;
  bridgeState_t nextState;
  logic         latchedWe;
  logic         acceptRequest;
  logic         counterIncrement;
  logic         timeoutExpired;
  logic         nextAck;
  logic         nextError;
  logic [31:0]  nextData;
  logic         nextWe;

  busy_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_busyTimeoutCounter (
    .clk      (clk),
    .rst      (rst),
    .clear    (acceptRequest),
    .increment(counterIncrement),
    .expired  (timeoutExpired)
  );

  // Next-state and response decode; abort outranks completion and timeout.
  always_comb begin
    nextState        = state;
    acceptRequest    = 1'b0;
    counterIncrement = 1'b0;
    nextAck          = 1'b0;
    nextError        = 1'b0;
    nextData         = wb.wb_data_o;
    case (state)
      IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          nextState     = REQUEST;
          acceptRequest = 1'b1;
        end else begin
          nextState = IDLE;
        end
      end
      REQUEST: begin
        if (!wb.wb_cyc_i) begin
          nextState = IDLE;
        end else if (!wb_management_busy) begin
          nextState = ACK;
          nextAck   = 1'b1;
          nextData  = latchedWe ? WRITE_RESPONSE_VALUE : wb_management_readData;
        end else if (timeoutExpired) begin
          nextState = ERROR;
          nextError = 1'b1;
          nextData  = ERROR_READ_VALUE;
        end else begin
          nextState        = REQUEST;
          counterIncrement = 1'b1;
        end
      end
      ACK:     nextState = IDLE;
      ERROR:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Direction of the request being driven next cycle (fresh or held).
  assign nextWe = acceptRequest ? wb.wb_we_i : latchedWe;

  // FSM state and registered bus responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wb.wb_ack_o   <= 1'b0;
      wb.wb_error_o <= 1'b0;
      wb.wb_data_o  <= 32'h0000_0000;
    end else begin
      state         <= nextState;
      wb.wb_ack_o   <= nextAck;
      wb.wb_error_o <= nextError;
      wb.wb_data_o  <= nextData;
    end
  end

  // Enables are high only while in REQUEST, so they follow nextState.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_management_writeEnable <= 1'b0;
      wb_management_readEnable  <= 1'b0;
    end else begin
      wb_management_writeEnable <= (nextState == REQUEST) && nextWe;
      wb_management_readEnable  <= (nextState == REQUEST) && !nextWe;
    end
  end

  // Request fields captured once on acceptance and held for the transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latchedWe                <= 1'b0;
      wb_management_byteSelect <= 4'h0;
      wb_management_address    <= '0;
      wb_management_writeData  <= 32'h0000_0000;
    end else if (acceptRequest) begin
      latchedWe                <= wb.wb_we_i;
      wb_management_byteSelect <= wb.wb_sel_i;
      wb_management_address    <= wb.wb_adr_i;
      wb_management_writeData  <= wb.wb_data_i;
    end else begin
      latchedWe                <= latchedWe;
      wb_management_byteSelect <= wb_management_byteSelect;
      wb_management_address    <= wb_management_address;
      wb_management_writeData  <= wb_management_writeData;
    end
  end

endmodule

// File: tb/tb_wishbone_management_bridge.sv
module tb_wishbone_management_bridge;
  import management_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wishbone_management_bridge_if bus();
  wishbone_management_bridge_if bus4();

  logic [31:0] mgmtReadData;
  logic        mgmtBusy;
  logic        mgmtBusy4;

  logic        writeEnable, readEnable;
  logic [3:0]  byteSelect;
  logic [19:0] address;
  logic [31:0] writeData;

  logic        writeEnable4, readEnable4;
  logic [3:0]  byteSelect4;
  logic [19:0] address4;
  logic [31:0] writeData4;

  wishbone_management_bridge dut (
    .clk                      (clk),
    .rst                      (rst),
    .wb                       (bus),
    .wb_management_writeEnable(writeEnable),
    .wb_management_readEnable (readEnable),
    .wb_management_byteSelect (byteSelect),
    .wb_management_address    (address),
    .wb_management_writeData  (writeData),
    .wb_management_readData   (mgmtReadData),
    .wb_management_busy       (mgmtBusy)
  );

  wishbone_management_bridge #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk                      (clk),
    .rst                      (rst),
    .wb                       (bus4),
    .wb_management_writeEnable(writeEnable4),
    .wb_management_readEnable (readEnable4),
    .wb_management_byteSelect (byteSelect4),
    .wb_management_address    (address4),
    .wb_management_writeData  (writeData4),
    .wb_management_readData   (mgmtReadData),
    .wb_management_busy       (mgmtBusy4)
  );

  typedef struct {
    logic        isError;
    logic [31:0] data;
  } response_t;

  int        vectorCount = 0;
  int        missCount   = 0;
  int        cycle       = 0;
  response_t expQ[$];
  int        ackCycles[$];
  response_t popped;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Scoreboard: every response from the main bridge must match the queue head.
  always @(negedge clk) begin
    if (!rst && (bus.wb_ack_o || bus.wb_error_o)) begin
      if (bus.wb_ack_o) ackCycles.push_back(cycle);
      if (expQ.size() == 0) begin
        checkValue("unexpectedResponse", 32'(bus.wb_ack_o | bus.wb_error_o), 32'd0);
      end else begin
        popped = expQ.pop_front();
        checkValue("respAck", 32'(bus.wb_ack_o), 32'(!popped.isError));
        checkValue("respError", 32'(bus.wb_error_o), 32'(popped.isError));
        checkValue("respData", bus.wb_data_o, popped.data);
      end
    end
  end

  task automatic startRequest(input logic we, input logic [19:0] adr, input logic [3:0] sel,
                              input logic [31:0] data, output logic ok);
    bus.wb_cyc_i  = 1'b1;
    bus.wb_stb_i  = 1'b1;
    bus.wb_we_i   = we;
    bus.wb_adr_i  = adr;
    bus.wb_sel_i  = sel;
    bus.wb_data_i = data;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (writeEnable || readEnable) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkValue("acceptTimeout", 32'd0, 32'd1);
  endtask

  task automatic doTransfer(input logic we, input logic [19:0] adr, input logic [3:0] sel,
                            input logic [31:0] data, input logic [31:0] rd, input int busyCycles);
    logic ok;
    logic stable;
    mgmtBusy     = (busyCycles > 0);
    mgmtReadData = 32'hDEAD_BEEF;
    startRequest(we, adr, sel, data, ok);
    if (ok) begin
      checkValue("writeEnable", 32'(writeEnable), 32'(we));
      checkValue("readEnable", 32'(readEnable), 32'(!we));
      checkValue("address", 32'(address), 32'(adr));
      checkValue("byteSelect", 32'(byteSelect), 32'(sel));
      checkValue("writeData", writeData, data);
      expQ.push_back('{isError: 1'b0, data: (we ? 32'd0 : rd)});
      stable = 1'b1;
      for (int c = 0; c <= busyCycles; c++) begin
        if (!(writeEnable == we && readEnable == !we && address == adr && byteSelect == sel &&
              writeData == data && !bus.wb_ack_o && !bus.wb_error_o)) stable = 1'b0;
        if (c == busyCycles) begin
          mgmtBusy     = 1'b0;
          mgmtReadData = rd;
        end
        @(negedge clk);
      end
      checkValue("requestHeld", 32'(stable), 32'd1);
      checkValue("ackTiming", 32'(bus.wb_ack_o), 32'd1);
      checkValue("enablesAfterAck", 32'({writeEnable, readEnable}), 32'd0);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   riseCycle, errCycle, errCount, ackCount;
    bus.wb_cyc_i = 1'b0;  bus.wb_stb_i = 1'b0;  bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 4'h0;  bus.wb_adr_i = 20'h0; bus.wb_data_i = 32'h0;
    bus4.wb_cyc_i = 1'b0; bus4.wb_stb_i = 1'b0; bus4.wb_we_i = 1'b0;
    bus4.wb_sel_i = 4'h0; bus4.wb_adr_i = 20'h0; bus4.wb_data_i = 32'h0;
    mgmtReadData = 32'h0; mgmtBusy = 1'b0; mgmtBusy4 = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    checkValue("resetFlags", 32'({bus.wb_ack_o, bus.wb_error_o, writeEnable, readEnable}), 32'd0);
    checkValue("resetData", bus.wb_data_o, 32'd0);
    checkValue("resetLatches", 32'(address) | 32'(byteSelect) | writeData, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic write, basic read, stalled read
    doTransfer(1'b1, 20'h00000, 4'hF, 32'h0000_0001, 32'h1357_9BDF, 0);
    doTransfer(1'b0, 20'h00004, 4'hF, 32'h0000_0000, 32'h0000_0013, 0);
    doTransfer(1'b0, 20'h00008, 4'h6, 32'h0000_0000, 32'hA5A5_0F0F, 5);

    // timeout on the TIMEOUT_CYCLES=4 instance
    bus4.wb_cyc_i = 1'b1; bus4.wb_stb_i = 1'b1; bus4.wb_we_i = 1'b0;
    bus4.wb_adr_i = 20'h00010; bus4.wb_sel_i = 4'hF;
    mgmtBusy4 = 1'b1;
    riseCycle = -100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (readEnable4) begin
        riseCycle = cycle;
        break;
      end
    end
    errCycle = -1; errCount = 0; ackCount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus4.wb_ack_o) ackCount++;
      if (bus4.wb_error_o) begin
        errCount++;
        if (errCycle < 0) begin
          errCycle = cycle;
          checkValue("timeoutData", bus4.wb_data_o, ERROR_READ_VALUE);
          checkValue("timeoutEnables", 32'({writeEnable4, readEnable4}), 32'd0);
          bus4.wb_cyc_i = 1'b0;
          bus4.wb_stb_i = 1'b0;
        end
      end
    end
    checkValue("timeoutLatency", 32'(errCycle - riseCycle), 32'd4);
    checkValue("timeoutPulses", 32'(errCount), 32'd1);
    checkValue("timeoutNoAck", 32'(ackCount), 32'd0);
    checkValue("enablesIdle4", 32'({writeEnable4, readEnable4}), 32'd0);
    mgmtBusy4 = 1'b0;

    // master abort while busy, then a normal write
    mgmtBusy = 1'b1;
    startRequest(1'b0, 20'h00020, 4'hF, 32'h0, ok);
    @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
    checkValue("abortEnables", 32'({writeEnable, readEnable}), 32'd0);
    repeat (3) @(negedge clk);
    doTransfer(1'b1, 20'h00024, 4'hC, 32'h1234_5678, 32'h0BAD_F00D, 0);

    // asynchronous reset mid-request
    mgmtBusy = 1'b1;
    startRequest(1'b1, 20'h00040, 4'h3, 32'hCAFE_F00D, ok);
    #2 rst = 1'b1;
    #1;
    checkValue("asyncResetEnables", 32'({writeEnable, readEnable}), 32'd0);
    checkValue("asyncResetFlags", 32'({bus.wb_ack_o, bus.wb_error_o}), 32'd0);
    checkValue("asyncResetData", bus.wb_data_o, 32'd0);
    checkValue("asyncResetAddress", 32'(address), 32'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    mgmtBusy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkValue("idleAfterReset", 32'({writeEnable, readEnable, bus.wb_ack_o}), 32'd0);

    // back-to-back writes: ack spacing
    ackCycles.delete();
    doTransfer(1'b1, 20'h00100, 4'hF, 32'h0000_00AA, 32'h0, 0);
    doTransfer(1'b1, 20'h00104, 4'h1, 32'h0000_00BB, 32'h0, 0);
    repeat (3) @(negedge clk);
    checkValue("ackCount", 32'(ackCycles.size()), 32'd2);
    if (ackCycles.size() == 2) checkValue("ackSpacing", 32'(ackCycles[1] - ackCycles[0]), 32'd3);
    checkValue("pendingResponses", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/wishbone_management_bridge.md
# wishbone_management_bridge

Wishbone classic slave that converts bus cycles from the SoC interconnect into the single-cycle-qualified `wb_management_*` request interface of the core management block. It registers each request, holds it until the management side stops signalling busy (JTAG has priority there), returns read data with `wb_ack_o`, and converts a stuck busy into `wb_error_o` after a bounded timeout. It sits directly upstream of core management on the Wishbone side.

## Interface
- `TIMEOUT_CYCLES`, default 255: busy cycles tolerated before an error response; legal range 1..255.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `wb_cyc_i` in 1: Wishbone cycle valid.
- `wb_stb_i` in 1: Wishbone strobe.
- `wb_we_i` in 1: 1 means write, 0 means read.
- `wb_sel_i` in 4: byte lanes.
- `wb_adr_i` in 20: byte address into management space.
- `wb_data_i` in 32: write data.
- `wb_ack_o` out 1: transfer complete, one-cycle pulse.
- `wb_error_o` out 1: timeout termination, one-cycle pulse.
- `wb_data_o` out 32: read data, valid while `wb_ack_o` or `wb_error_o` is high.
- `wb_management_writeEnable` out 1: write request to management.
- `wb_management_readEnable` out 1: read request to management.
- `wb_management_byteSelect` out 4: latched `wb_sel_i`.
- `wb_management_address` out 20: latched `wb_adr_i`.
- `wb_management_writeData` out 32: latched `wb_data_i`.
- `wb_management_readData` in 32: management read data.
- `wb_management_busy` in 1: management is serving JTAG, so this request is stalled.

## Operation
- FSM states:
  - IDLE: no request driven.
  - REQUEST: request driven, waiting for busy to drop.
  - ACK: one-cycle `wb_ack_o`.
  - ERROR: one-cycle `wb_error_o`.
- IDLE → REQUEST when `wb_cyc_i & wb_stb_i`:
  - latch `wb_adr_i`, `wb_sel_i`, `wb_data_i` and `wb_we_i`;
  - clear the timeout counter.
- In REQUEST, exactly one of `writeEnable` / `readEnable` is high, set by the latched `we`. Address, byteSelect and writeData are stable for the whole state.
- REQUEST with `busy == 0` → ACK:
  - `wb_data_o` ← `wb_management_readData` on reads;
  - `wb_data_o` ← 0 on writes.
- REQUEST with `busy == 1`:
  - counter increments;
  - when the counter equals `TIMEOUT_CYCLES - 1` while still busy → ERROR, with `wb_data_o` ← 32'hFFFF_FFFF.
- REQUEST with `wb_cyc_i == 0` (master abort) → IDLE:
  - no ack, no error;
  - enables drop next cycle;
  - abort has priority over the completion and timeout transitions.
- ACK and ERROR always → IDLE. In those states a new strobe is not accepted; it is sampled in IDLE on the following cycle.
- Enables are cleared in every state except REQUEST. Management therefore never sees a request for more than one transfer.
- Counter is 8 bits and saturates; it never wraps.
- Reset values:
  - state IDLE;
  - all enables, `wb_ack_o` and `wb_error_o` at 0;
  - `wb_data_o`, latched address/sel/data and counter at 0.
- Reset asserted mid-REQUEST: enables drop asynchronously and no ack is issued.

## Timing
- Strobe sampled at edge N → enables high from N to N+1.
- Busy low at edge N+1 → `wb_ack_o` high N+1 to N+2. Minimum latency from strobe to ack is 1 cycle after the request cycle, i.e. ack visible to the master at edge N+2.
- Each busy cycle adds one cycle. The error pulse appears `TIMEOUT_CYCLES` cycles after enables rise if busy never drops.
- Throughput is at most one transfer per 3 cycles (IDLE, REQUEST, ACK).
- All outputs are registered; there is no combinational path from `wb_*_i` or `busy` to any output.

## Structure
- Shared package `management_bus_pkg`:
  - FSM state localparams: IDLE=2'd0, REQUEST=2'd1, ACK=2'd2, ERROR=2'd3;
  - `MANAGEMENT_ADDRESS_WIDTH = 20`;
  - error read value 32'hFFFF_FFFF.
- One sub-module: `busy_timeout_counter`.
  - Inputs: `clk`, `rst`, clear, increment.
  - Output: `expired`.
  - Parameterised by `TIMEOUT_CYCLES`.
- Remaining logic (FSM, latches, output registers) lives in the top module.

## Test plan
- Write, busy=0: addr 0x00000, sel 4'hF, data 0x1 → `writeEnable` high exactly 1 cycle with those values; ack 1 cycle later; `wb_data_o` = 0.
- Read, busy=0: addr 0x00004, `readData` = 0x00000013 → `readEnable` 1 cycle; ack with `wb_data_o` = 0x13.
- Read with busy high for 5 cycles then low: `readEnable` held 6 cycles with stable address; single ack; data captured in the cycle busy falls.
- `TIMEOUT_CYCLES` = 4, busy stuck high → `wb_error_o` 1 cycle exactly 4 cycles after enable rise; `wb_data_o` = 0xFFFFFFFF; enables low afterwards; no ack.
- Abort: `wb_cyc_i` dropped during REQUEST with busy high → enables low next cycle; no ack or error; a following write completes normally.
- Reset asserted mid-REQUEST → all outputs 0 immediately (asynchronously); state IDLE after release; back-to-back writes give 3-cycle spacing between acks.
